// File: rtl/red_pitaya_exp_filter.sv
// Expansion-bank input conditioner: 2-FF sync, per-bit debounce, bus registers.
// Optional edge events + irq when EXP_FILTER_EDGE_EN is defined.
module red_pitaya_exp_filter_lane #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sync,
  input  logic [CW-1:0] dbl,
  output logic          filt
);
  logic [CW-1:0] cnt;

  // Counter only runs while the synced level disagrees with the filtered one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt >= dbl) begin
      filt <= sync;
      cnt  <= '0;
    end else if (cnt != {CW{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module red_pitaya_exp_filter #(
  parameter int            DWE     = 8,
  parameter int            CW      = 16,
  parameter logic [CW-1:0] DBL_RST = 16'd1250
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [DWE-1:0] exp_dat_i,
  output logic [DWE-1:0] exp_dat_o,
  output logic           irq_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);
`ifdef EXP_FILTER_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic [DWE-1:0] meta, sync, filt;
  logic [CW-1:0]  dbl;
  logic [19:0]    addr;
  logic [31:0]    rmux;
  logic           unused_bits;

  assign addr        = sys_addr[19:0];
  assign unused_bits = ^{sys_addr[31:20], sys_wdata};
  assign exp_dat_o   = filt;
  assign sys_err     = 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= exp_dat_i;
      sync <= meta;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DWE; g++) begin : g_lane
      red_pitaya_exp_filter_lane #(.CW(CW)) u_lane (
        .clk  (clk_i),
        .rstn (rstn_i),
        .sync (sync[g]),
        .dbl  (dbl),
        .filt (filt[g])
      );
    end
  endgenerate

`ifdef EXP_FILTER_EDGE_EN
  logic [DWE-1:0] filt_q, rise, fall, rise_evt, fall_evt, rise_clr, fall_clr;
  logic           irq_r;

  assign rise     = filt & ~filt_q;
  assign fall     = ~filt & filt_q;
  assign rise_clr = (sys_wen && addr == 20'h08) ? sys_wdata[DWE-1:0] : '0;
  assign fall_clr = (sys_wen && addr == 20'h0C) ? sys_wdata[DWE-1:0] : '0;
  assign irq_o    = irq_r;

  // A new edge in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      filt_q   <= '0;
      rise_evt <= '0;
      fall_evt <= '0;
      irq_r    <= 1'b0;
    end else begin
      filt_q   <= filt;
      rise_evt <= (rise_evt & ~rise_clr) | rise;
      fall_evt <= (fall_evt & ~fall_clr) | fall;
      irq_r    <= |{rise_evt, fall_evt};
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rmux = '0;
    case (addr)
      20'h00: rmux = 32'(filt);
      20'h04: rmux = 32'(dbl);
`ifdef EXP_FILTER_EDGE_EN
      20'h08: rmux = 32'(rise_evt);
      20'h0C: rmux = 32'(fall_evt);
`endif
      20'h10: rmux = 32'(sync);
      20'h14: rmux = {EDGE, 15'd0, 8'(CW), 8'(DWE)};
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      dbl       <= DBL_RST;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rmux : 32'd0;
      if (sys_wen && addr == 20'h04) dbl <= sys_wdata[CW-1:0];
    end
  end
endmodule

// File: doc/red_pitaya_exp_filter.md
# red_pitaya_exp_filter

Input conditioning stage for one expansion-connector bank, sitting directly upstream of housekeeping's `exp_p_dat_i`/`exp_n_dat_i` inputs; one instance per P and N bank. It synchronizes raw pad inputs, debounces each bit with a programmable hold time, and drives the clean levels to housekeeping. Optionally it also latches rising and falling edge events into sticky bus-readable registers with an interrupt line. It has its own system-bus register window.

## Interface
- `DWE`, 8: bank width in bits.
- `CW`, 16: debounce counter and threshold width.
- `DBL_RST`, 16'd1250: reset value of the debounce threshold (10 µs at 125 MHz).
- `clk_i`  in  1: system clock, 125 MHz.
- `rstn_i`  in  1: reset. **Synchronous, active-low.**
- `exp_dat_i`  in  DWE: raw pad inputs, asynchronous to `clk_i`.
- `exp_dat_o`  out  DWE: debounced levels, connected to housekeeping `exp_*_dat_i`.
- `irq_o`  out  1: registered OR of all pending edge events.
- `sys_addr`  in  32: bus address. Only bits [19:0] are decoded.
- `sys_wdata`  in  32: bus write data.
- `sys_wen`  in  1: write strobe.
- `sys_ren`  in  1: read strobe.
- `sys_rdata`  out  32: read data.
- `sys_err`  out  1: always 0.
- `sys_ack`  out  1: acknowledge.

## Operation
- **Synchronizer:** 2-FF chain per bit, giving `sync`.
- **Debounce, per bit:**
  - When `sync == filt`: `cnt <= 0`.
  - Otherwise, if `cnt >= dbl`: `filt <= sync` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - The counter saturates at all-ones and never wraps.
  - `exp_dat_o = filt`.
- **Threshold `dbl`:**
  - Changes take effect on the cycle after the write. Running counters are not cleared.
  - If the new `dbl` is below a running `cnt`, that bit flips on its next differing cycle.
  - `dbl = 0` means no filtering: `filt` follows `sync` with one extra cycle.
- **Edge detect:** `filt_q` holds `filt` delayed one cycle.
  - `rise = filt & ~filt_q`.
  - `fall = ~filt & filt_q`.
- **Sticky events** (`rise_evt`, `fall_evt`):
  - Set by `rise` / `fall`.
  - Cleared by writing 1 to the corresponding bit (W1C).
  - A set and a clear in the same cycle on the same bit: set wins.
- **Register map** (`sys_addr[19:0]`):
  - 0x00, RO: `filt`.
  - 0x04, RW: `dbl[CW-1:0]`.
  - 0x08, W1C: `rise_evt`.
  - 0x0C, W1C: `fall_evt`.
  - 0x10, RO: `sync`.
  - 0x14, RO: constant `{CW, DWE}` capability word (`[15:8]=CW`, `[7:0]=DWE`).
  - Any other address reads 0, and writes to it are ignored.
  - Unused upper bits read 0.

## Timing
- **Reset values:**
  - `sync`, `filt`, `filt_q`, `cnt`, `rise_evt`, `fall_evt`: 0.
  - `dbl`: `DBL_RST`.
  - `exp_dat_o`, `irq_o`, `sys_ack`, `sys_rdata`: 0.
  - `sys_err`: 0.
- **Input latency:** a stable raw change reaches `exp_dat_o` exactly `dbl + 3` clocks after the input edge is sampled (2 sync stages + `dbl` counts + 1 update).
- **Glitch rejection:** a `sync` pulse lasting ≤ `dbl` cycles is rejected, and `cnt` returns to 0.
- **Event latency:** an event bit sets 1 clock after the `filt` change. `irq_o` rises 1 clock after that.
- **Bus handshake:**
  - `sys_ack <= sys_wen | sys_ren` every cycle, so it is a single-cycle acknowledge one clock after the strobe.
  - `sys_rdata` is registered in the same cycle as the ack. Its content reflects the register state before any write in the same cycle.
- **Back-to-back accesses:** each strobe cycle is acknowledged, with no stalls.
- **Reset during debounce:** `cnt` and `filt` are forced to 0 synchronously. A pad held high leaves reset and reaches `exp_dat_o` after `DBL_RST + 3` clocks.

## Configuration
- Macro: `EXP_FILTER_EDGE_EN`.
- **Defined:** edge detect, sticky event registers at 0x08/0x0C and `irq_o` are implemented as described above.
- **Undefined:**
  - No event logic is synthesized.
  - 0x08/0x0C read 0 and writes to them are ignored.
  - `irq_o` is tied to 0.
  - Capability word bit 31 reads 0. (Defined: bit 31 reads 1.)
- Synchronizer, debounce and the remaining registers are identical in both builds.

## Test plan
- **Reset:** after reset release, read 0x04 → 0x000004E2. `exp_dat_o` is 0 and `irq_o` is 0.
- **Unfiltered path:** write `dbl = 0`, drive `exp_dat_i = 0x5A` → `exp_dat_o = 0x5A` exactly 3 clocks later. Reading 0x00 returns 0x5A with `sys_ack` 1 clock after the strobe.
- **Debounce reject/accept:** with `dbl = 10`:
  - A bit-0 pulse of 10 clocks → `exp_dat_o` unchanged.
  - A pulse of 20 clocks → bit 0 rises exactly 13 clocks after the pulse start.
- **Threshold change mid-count:** `dbl = 100`, hold a changed input for 50 cycles, then write `dbl = 20` → output flips on the next cycle after the write takes effect.
- **Edge capture** (`EXP_FILTER_EDGE_EN`):
  - Rise then fall on bit 3 → 0x08 reads 0x08, 0x0C reads 0x08, and `irq_o` = 1.
  - Write 0x08 to both registers → both read 0 and `irq_o` falls.
  - A W1C issued in the same cycle as a new rise → the bit stays set.
- **Edge capture disabled** (macro undefined): identical stimulus → 0x08/0x0C read 0, `irq_o` stays 0, capability word = 0x00001008.
